// File: rtl/dram_bus_arbiter_pkg.sv
// Shared types and constants for the two-master DRAM bus arbiter.
// Holds the arbiter state encoding and the bundle carried from a master to the DRAM side.
package dram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_A = 2'b01,
    ST_GRANT_B = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_t;

  localparam logic STROBE_OFF = 1'b1;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  // Everything a master presents to the DRAM controller; strobes are active low.
  typedef struct packed {
    logic        sel_n;
    logic        as_n;
    logic        we_n;
    logic        uds_n;
    logic        lds_n;
    logic [31:0] addr;
    logic [15:0] wdata;
  } dram_bus_t;

  localparam dram_bus_t BUS_IDLE = '{
    sel_n: STROBE_OFF, as_n: STROBE_OFF, we_n: STROBE_OFF,
    uds_n: STROBE_OFF, lds_n: STROBE_OFF, addr: 32'h0, wdata: 16'h0
  };

endpackage

// File: rtl/dram_bus_arbiter_port_mux.sv
// Combinational 2:1 selection of the granted master's bus bundle onto the DRAM side,
// plus routing of the DRAM Dtack back to the granted master only.
module arb_port_mux
  import dram_bus_arbiter_pkg::*;
(
  input  logic      grant_a,
  input  logic      grant_b,
  input  dram_bus_t bus_a,
  input  dram_bus_t bus_b,
  input  logic      dtack_dram,
  output dram_bus_t bus_dram,
  output logic      dtack_a,
  output logic      dtack_b
);

  always_comb begin
    bus_dram = BUS_IDLE;
    dtack_a  = STROBE_OFF;
    dtack_b  = STROBE_OFF;
    if (grant_a) begin
      bus_dram = bus_a;
      dtack_a  = dtack_dram;
    end else if (grant_b) begin
      bus_dram = bus_b;
      dtack_b  = dtack_dram;
    end
  end

endmodule

// File: rtl/dram_bus_arbiter.sv
// Two-master DRAM bus arbiter: port A has priority, port B is guaranteed service after
// MaxConsecA back-to-back A grants; grants are held for a master's whole bus cycle.
module dram_bus_arbiter
  import dram_bus_arbiter_pkg::*;
#(
  parameter int MaxConsecA = 4,
  parameter int GapCycles  = 1
) (
  input  logic        Clock,
  input  logic        Reset_H,
  input  logic        SelA_L,
  input  logic        SelB_L,
  input  logic        ASA_L,
  input  logic        ASB_L,
  input  logic        WEA_L,
  input  logic        WEB_L,
  input  logic        UDSA_L,
  input  logic        LDSA_L,
  input  logic        UDSB_L,
  input  logic        LDSB_L,
  input  logic [31:0] AddrA,
  input  logic [31:0] AddrB,
  input  logic [15:0] WDataA,
  input  logic [15:0] WDataB,
  input  logic        DtackFromDram_L,
  output logic        DramSelect_L,
  output logic        AS_Dram_L,
  output logic        WE_Dram_L,
  output logic        UDS_Dram_L,
  output logic        LDS_Dram_L,
  output logic [31:0] Addr_Dram,
  output logic [15:0] WData_Dram,
  output logic        DtackA_L,
  output logic        DtackB_L,
  output logic        GrantA_H,
  output logic        GrantB_H,
  output logic [1:0]  ArbState
);

  arb_state_t state_reg, state_next;
  logic [3:0] consec_a_reg, consec_a_next;
  logic [2:0] gap_cnt_reg, gap_cnt_next;

  logic req_a, req_b, end_a, end_b;
  dram_bus_t port_bus [2];
  dram_bus_t dram_bus;

  assign req_a = !SelA_L && !ASA_L;
  assign req_b = !SelB_L && !ASB_L;
  assign end_a = SelA_L && ASA_L;
  assign end_b = SelB_L && ASB_L;

  always_ff @(posedge Clock or posedge Reset_H) begin
    if (Reset_H) begin
      state_reg    <= ST_IDLE;
      consec_a_reg <= 4'd0;
      gap_cnt_reg  <= 3'd0;
    end else begin
      state_reg    <= state_next;
      consec_a_reg <= consec_a_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    consec_a_next = consec_a_reg;
    gap_cnt_next  = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!req_b) consec_a_next = 4'd0;
        if (req_a && req_b) begin
          // B wins only once A has had its quota of consecutive grants.
          if (consec_a_reg == 4'(MaxConsecA)) begin
            state_next    = ST_GRANT_B;
            consec_a_next = 4'd0;
          end else begin
            state_next    = ST_GRANT_A;
            consec_a_next = consec_a_reg + 4'd1;
          end
        end else if (req_a) begin
          state_next = ST_GRANT_A;
        end else if (req_b) begin
          state_next    = ST_GRANT_B;
          consec_a_next = 4'd0;
        end
      end
      ST_GRANT_A: if (end_a) state_next = ST_RELEASE;
      ST_GRANT_B: if (end_b) state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (gap_cnt_reg == 3'(GapCycles - 1)) begin
          state_next   = ST_IDLE;
          gap_cnt_next = 3'd0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 3'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign port_bus[PORT_A] = '{sel_n: SelA_L, as_n: ASA_L, we_n: WEA_L, uds_n: UDSA_L,
                              lds_n: LDSA_L, addr: AddrA, wdata: WDataA};
  assign port_bus[PORT_B] = '{sel_n: SelB_L, as_n: ASB_L, we_n: WEB_L, uds_n: UDSB_L,
                              lds_n: LDSB_L, addr: AddrB, wdata: WDataB};

  assign GrantA_H = (state_reg == ST_GRANT_A);
  assign GrantB_H = (state_reg == ST_GRANT_B);
  assign ArbState = state_reg;

  arb_port_mux u_mux (
    .grant_a    (GrantA_H),
    .grant_b    (GrantB_H),
    .bus_a      (port_bus[PORT_A]),
    .bus_b      (port_bus[PORT_B]),
    .dtack_dram (DtackFromDram_L),
    .bus_dram   (dram_bus),
    .dtack_a    (DtackA_L),
    .dtack_b    (DtackB_L)
  );

  assign DramSelect_L = dram_bus.sel_n;
  assign AS_Dram_L    = dram_bus.as_n;
  assign WE_Dram_L    = dram_bus.we_n;
  assign UDS_Dram_L   = dram_bus.uds_n;
  assign LDS_Dram_L   = dram_bus.lds_n;
  assign Addr_Dram    = dram_bus.addr;
  assign WData_Dram   = dram_bus.wdata;

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Directed self-checking bench for dram_bus_arbiter (MaxConsecA = 4, GapCycles = 1).
module tb_dram_bus_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_H;
  logic        SelA_L, SelB_L, ASA_L, ASB_L, WEA_L, WEB_L;
  logic        UDSA_L, LDSA_L, UDSB_L, LDSB_L;
  logic [31:0] AddrA, AddrB;
  logic [15:0] WDataA, WDataB;
  logic        DtackFromDram_L;
  logic        DramSelect_L, AS_Dram_L, WE_Dram_L, UDS_Dram_L, LDS_Dram_L;
  logic [31:0] Addr_Dram;
  logic [15:0] WData_Dram;
  logic        DtackA_L, DtackB_L, GrantA_H, GrantB_H;
  logic [1:0]  ArbState;

  int total = 0;
  int bad   = 0;

  dram_bus_arbiter #(.MaxConsecA(4), .GapCycles(1)) dut (
    .Clock(Clock), .Reset_H(Reset_H),
    .SelA_L(SelA_L), .SelB_L(SelB_L), .ASA_L(ASA_L), .ASB_L(ASB_L),
    .WEA_L(WEA_L), .WEB_L(WEB_L), .UDSA_L(UDSA_L), .LDSA_L(LDSA_L),
    .UDSB_L(UDSB_L), .LDSB_L(LDSB_L), .AddrA(AddrA), .AddrB(AddrB),
    .WDataA(WDataA), .WDataB(WDataB), .DtackFromDram_L(DtackFromDram_L),
    .DramSelect_L(DramSelect_L), .AS_Dram_L(AS_Dram_L), .WE_Dram_L(WE_Dram_L),
    .UDS_Dram_L(UDS_Dram_L), .LDS_Dram_L(LDS_Dram_L), .Addr_Dram(Addr_Dram),
    .WData_Dram(WData_Dram), .DtackA_L(DtackA_L), .DtackB_L(DtackB_L),
    .GrantA_H(GrantA_H), .GrantB_H(GrantB_H), .ArbState(ArbState)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs;
    SelA_L = 1; ASA_L = 1; WEA_L = 1; UDSA_L = 1; LDSA_L = 1;
    SelB_L = 1; ASB_L = 1; WEB_L = 1; UDSB_L = 1; LDSB_L = 1;
    AddrA = 32'h0; AddrB = 32'h0; WDataA = 16'h0; WDataB = 16'h0;
    DtackFromDram_L = 1;
  endtask

  task automatic do_reset;
    idle_inputs();
    Reset_H = 1;
    #3;
    Reset_H = 0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    SelA_L = 0; ASA_L = 0; UDSA_L = 0; LDSA_L = 0; DtackFromDram_L = 0;
    tick();
    total++;
    if (AS_Dram_L !== 1'b0 || GrantA_H !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre: AS_Dram_L=%b GrantA_H=%b required 0/1", AS_Dram_L, GrantA_H);
    end
    Reset_H = 1;
    #1;
    total++;
    if ({DramSelect_L, AS_Dram_L, WE_Dram_L, UDS_Dram_L, LDS_Dram_L, DtackA_L, DtackB_L} !== 7'h7f
        || GrantA_H !== 1'b0 || GrantB_H !== 1'b0 || Addr_Dram !== 32'h0 || WData_Dram !== 16'h0) begin
      bad++;
      $display("FAIL reset_async: strobes=%b dtack=%b%b grant=%b%b addr=%h required all ones, grants 0, addr 0",
               {DramSelect_L, AS_Dram_L, WE_Dram_L, UDS_Dram_L, LDS_Dram_L}, DtackA_L, DtackB_L,
               GrantA_H, GrantB_H, Addr_Dram);
    end
    idle_inputs();
    #1;
    Reset_H = 0;
    tick();
    total++;
    if (ArbState !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: ArbState=%b required 00", ArbState);
    end
    $display("test_reset done");
  endtask

  task automatic test_a_burst;
    logic exp_dtack;
    do_reset();
    AddrA = 32'h0800_0010; WDataA = 16'h5555;
    SelA_L = 0; ASA_L = 0; WEA_L = 1; UDSA_L = 0; LDSA_L = 0;
    tick();
    total++;
    if (Addr_Dram !== 32'h0800_0010 || ArbState !== 2'b01 || AS_Dram_L !== 1'b0) begin
      bad++;
      $display("FAIL a_burst_grant: Addr_Dram=%h ArbState=%b AS=%b required 08000010/01/0",
               Addr_Dram, ArbState, AS_Dram_L);
    end
    for (int i = 0; i < 8; i++) begin
      exp_dtack = (i % 3 == 2);
      DtackFromDram_L = exp_dtack;
      #1;
      total++;
      if (DtackA_L !== exp_dtack || DtackB_L !== 1'b1 || GrantA_H !== 1'b1) begin
        bad++;
        $display("FAIL a_burst_dtack[%0d]: DtackA_L=%b DtackB_L=%b GrantA_H=%b required %b/1/1",
                 i, DtackA_L, DtackB_L, GrantA_H, exp_dtack);
      end
      tick();
    end
    SelA_L = 1; ASA_L = 1; DtackFromDram_L = 1;
    tick();
    total++;
    if (ArbState !== 2'b11 || AS_Dram_L !== 1'b1 || Addr_Dram !== 32'h0) begin
      bad++;
      $display("FAIL a_burst_release: ArbState=%b AS=%b Addr=%h required 11/1/0", ArbState, AS_Dram_L, Addr_Dram);
    end
    $display("test_a_burst done");
  endtask

  task automatic test_simultaneous;
    int high_cnt;
    bit got_b;
    do_reset();
    AddrA = 32'h0000_1000; AddrB = 32'h0000_2000;
    SelA_L = 0; ASA_L = 0; SelB_L = 0; ASB_L = 0;
    tick();
    total++;
    if (GrantA_H !== 1'b1 || GrantB_H !== 1'b0 || Addr_Dram !== 32'h0000_1000) begin
      bad++;
      $display("FAIL simul_first: GrantA_H=%b GrantB_H=%b Addr=%h required 1/0/00001000", GrantA_H, GrantB_H, Addr_Dram);
    end
    tick();
    SelA_L = 1; ASA_L = 1;
    high_cnt = 0;
    got_b = 0;
    for (int i = 0; i < 20 && !got_b; i++) begin
      tick();
      if (GrantB_H) got_b = 1;
      else if (AS_Dram_L === 1'b1) high_cnt++;
    end
    total++;
    if (!got_b || high_cnt != 2 || Addr_Dram !== 32'h0000_2000 || AS_Dram_L !== 1'b0) begin
      bad++;
      $display("FAIL simul_gap: got_b=%0d gap=%0d Addr=%h required 1/2/00002000", got_b, high_cnt, Addr_Dram);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_starvation;
    do_reset();
    SelA_L = 0; ASA_L = 0; SelB_L = 0; ASB_L = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (GrantA_H !== 1'b1 || GrantB_H !== 1'b0 || dut.consec_a_reg !== 4'(k + 1)) begin
        bad++;
        $display("FAIL starve_a[%0d]: GrantA_H=%b GrantB_H=%b consec=%0d required 1/0/%0d",
                 k, GrantA_H, GrantB_H, dut.consec_a_reg, k + 1);
      end
      SelA_L = 1; ASA_L = 1;
      tick();
      SelA_L = 0; ASA_L = 0;
      tick();
      total++;
      if (ArbState !== 2'b00) begin
        bad++;
        $display("FAIL starve_idle[%0d]: ArbState=%b required 00", k, ArbState);
      end
    end
    tick();
    total++;
    if (GrantB_H !== 1'b1 || GrantA_H !== 1'b0 || dut.consec_a_reg !== 4'd0) begin
      bad++;
      $display("FAIL starve_b: GrantB_H=%b GrantA_H=%b consec=%0d required 1/0/0", GrantB_H, GrantA_H, dut.consec_a_reg);
    end
    $display("test_starvation done");
  endtask

  task automatic test_b_write;
    do_reset();
    WDataA = 16'h1234; AddrA = 32'h0000_0044; WEA_L = 0;
    AddrB = 32'h0800_0100; WDataB = 16'hBEEF;
    SelB_L = 0; ASB_L = 0; WEB_L = 0; UDSB_L = 0; LDSB_L = 1;
    tick();
    total++;
    if (WE_Dram_L !== 1'b0 || WData_Dram !== 16'hBEEF || UDS_Dram_L !== 1'b0 || LDS_Dram_L !== 1'b1
        || Addr_Dram !== 32'h0800_0100 || DramSelect_L !== 1'b0) begin
      bad++;
      $display("FAIL b_write_bus: WE=%b WData=%h UDS=%b LDS=%b Addr=%h Sel=%b required 0/BEEF/0/1/08000100/0",
               WE_Dram_L, WData_Dram, UDS_Dram_L, LDS_Dram_L, Addr_Dram, DramSelect_L);
    end
    DtackFromDram_L = 0;
    #1;
    total++;
    if (DtackB_L !== 1'b0 || DtackA_L !== 1'b1 || WData_Dram === 16'h1234) begin
      bad++;
      $display("FAIL b_write_dtack: DtackB_L=%b DtackA_L=%b WData=%h required 0/1/BEEF", DtackB_L, DtackA_L, WData_Dram);
    end
    $display("test_b_write done");
  endtask

  task automatic test_b_pulse;
    do_reset();
    SelA_L = 0; ASA_L = 0;
    tick();
    SelB_L = 0; ASB_L = 0;
    tick();
    SelB_L = 1; ASB_L = 1;
    DtackFromDram_L = 0;
    tick();
    total++;
    if (GrantA_H !== 1'b1 || GrantB_H !== 1'b0 || DtackB_L !== 1'b1 || DtackA_L !== 1'b0) begin
      bad++;
      $display("FAIL b_pulse_hold: GrantA_H=%b GrantB_H=%b DtackB_L=%b DtackA_L=%b required 1/0/1/0",
               GrantA_H, GrantB_H, DtackB_L, DtackA_L);
    end
    SelA_L = 1; ASA_L = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (GrantB_H !== 1'b0 || DtackB_L !== 1'b1) begin
        bad++;
        $display("FAIL b_pulse_after[%0d]: GrantB_H=%b DtackB_L=%b required 0/1", i, GrantB_H, DtackB_L);
      end
    end
    total++;
    if (ArbState !== 2'b00) begin
      bad++;
      $display("FAIL b_pulse_idle: ArbState=%b required 00", ArbState);
    end
    $display("test_b_pulse done");
  endtask

  initial begin
    idle_inputs();
    Reset_H = 1;
    #2;
    test_reset();
    test_a_burst();
    test_simultaneous();
    test_starvation();
    test_b_write();
    test_b_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
